// File: rtl/pll_lock_seq_if.sv
// Control and status bundle between the PLL lock sequencer and its host.
// The host (master) drives the enable, restart and PFD inputs. The sequencer (slave) returns the loop controls and status.
interface pll_lock_seq_if;
    logic       enable;
    logic       restart;
    logic       up;
    logic       down;
    logic       cp_en;
    logic       cp_gain_hi;
    logic       lf_reset;
    logic       locked;
    logic [2:0] state;
    logic [7:0] relock_cnt;

    modport master (
        output enable, restart, up, down,
        input  cp_en, cp_gain_hi, lf_reset, locked, state, relock_cnt
    );

    modport slave (
        input  enable, restart, up, down,
        output cp_en, cp_gain_hi, lf_reset, locked, state, relock_cnt
    );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL lock-acquisition sequencer: resets the loop filter, then runs the charge pump at high gain and then at tracking gain.
// Lock is declared after enough quiet PFD windows, and lock losses and acquisition timeouts are counted.
module pll_lock_seq #(
    parameter int WIN_LEN      = 64,
    parameter int RST_CYC      = 16,
    parameter int LOCK_TOL     = 4,
    parameter int UNLOCK_TOL   = 16,
    parameter int ACQ_GOOD     = 2,
    parameter int LOCK_WINS    = 4,
    parameter int TIMEOUT_WINS = 32
) (
    input  logic           refclk,
    input  logic           rst_n,
    pll_lock_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LF_RST  = 3'd1,
        S_ACQUIRE = 3'd2,
        S_TRACK   = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    localparam int WC_W     = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int ACT_W    = $clog2(WIN_LEN + 1);
    localparam int GOOD_MAX = (ACQ_GOOD > LOCK_WINS) ? ACQ_GOOD : LOCK_WINS;
    localparam int GC_W     = $clog2(GOOD_MAX + 1);
    localparam int WN_W     = $clog2(TIMEOUT_WINS + 1);
    localparam int RC_W     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int LOCK_C   = (LOCK_TOL < WIN_LEN) ? LOCK_TOL : WIN_LEN;
    localparam int UNLOCK_C = (UNLOCK_TOL < WIN_LEN) ? UNLOCK_TOL : WIN_LEN;

    localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(WIN_LEN - 1);
    localparam logic [ACT_W-1:0] ACT_MAX   = ACT_W'(WIN_LEN);
    localparam logic [ACT_W-1:0] LOCK_TH   = ACT_W'(LOCK_C);
    localparam logic [ACT_W-1:0] UNLOCK_TH = ACT_W'(UNLOCK_C);
    localparam logic [GC_W-1:0]  ACQ_LAST  = GC_W'(ACQ_GOOD - 1);
    localparam logic [GC_W-1:0]  LOCK_LAST = GC_W'(LOCK_WINS - 1);
    localparam logic [WN_W-1:0]  WIN_LAST  = WN_W'(TIMEOUT_WINS - 1);
    localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(RST_CYC - 1);

    state_t            state_q, state_nx;
    logic [WC_W-1:0]   wc_q;
    logic [ACT_W-1:0]  act_q, act_sum;
    logic [GC_W-1:0]   good_q, good_nx;
    logic [WN_W-1:0]   win_q, win_nx;
    logic [RC_W-1:0]   rc_q;
    logic [7:0]        relock_q;
    logic              relock_inc;
    logic              eval, good_win, bad_win, entry;
    logic              cp_en_q, gain_q, lf_q, locked_q;
    logic              cp_en_nx, gain_nx, lf_nx, locked_nx;

    // Window activity: the evaluation cycle's own activity is folded in before comparing.
    always_comb begin
        act_sum = act_q;
        if ((bus.up | bus.down) && (act_q != ACT_MAX))
            act_sum = act_q + 1'b1;
        eval     = (wc_q == WC_LAST);
        good_win = eval && (act_sum <= LOCK_TH);
        bad_win  = eval && (act_sum > UNLOCK_TH);
    end

    always_comb begin
        state_nx   = state_q;
        good_nx    = good_q;
        win_nx     = win_q;
        relock_inc = 1'b0;
        if (!bus.enable) begin
            state_nx = S_IDLE;
            good_nx  = '0;
            win_nx   = '0;
        end else if (bus.restart) begin
            state_nx = S_LF_RST;
        end else begin
            case (state_q)
                S_IDLE:   state_nx = S_LF_RST;
                S_LF_RST: if (rc_q == RC_LAST) state_nx = S_ACQUIRE;
                S_ACQUIRE: begin
                    if (eval) begin
                        win_nx  = win_q + 1'b1;
                        good_nx = good_win ? good_q + 1'b1 : '0;
                        // Reaching TRACK takes precedence over a timeout on the same window.
                        if (good_win && (good_q == ACQ_LAST)) begin
                            state_nx = S_TRACK;
                        end else if (win_q == WIN_LAST) begin
                            state_nx   = S_LF_RST;
                            relock_inc = 1'b1;
                        end
                    end
                end
                S_TRACK: begin
                    if (eval) begin
                        good_nx = good_win ? good_q + 1'b1 : '0;
                        if (bad_win)
                            state_nx = S_ACQUIRE;
                        else if (good_win && (good_q == LOCK_LAST))
                            state_nx = S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (bad_win) begin
                        state_nx   = S_ACQUIRE;
                        relock_inc = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end

        // A restart re-enters LF_RST even when already there, so it counts as an entry.
        entry = (state_nx != state_q) || (bus.enable && bus.restart);

        cp_en_nx  = 1'b0;
        gain_nx   = 1'b0;
        lf_nx     = 1'b0;
        locked_nx = 1'b0;
        case (state_nx)
            S_LF_RST:  lf_nx = 1'b1;
            S_ACQUIRE: begin
                cp_en_nx = 1'b1;
                gain_nx  = 1'b1;
            end
            S_TRACK:   cp_en_nx = 1'b1;
            S_LOCKED: begin
                cp_en_nx  = 1'b1;
                locked_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cp_en_q  <= 1'b0;
            gain_q   <= 1'b0;
            lf_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_nx;
            cp_en_q  <= cp_en_nx;
            gain_q   <= gain_nx;
            lf_q     <= lf_nx;
            locked_q <= locked_nx;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q   <= '0;
            act_q  <= '0;
            good_q <= '0;
            win_q  <= '0;
            rc_q   <= '0;
        end else if (entry) begin
            wc_q   <= '0;
            act_q  <= '0;
            good_q <= '0;
            win_q  <= '0;
            rc_q   <= '0;
        end else begin
            wc_q   <= eval ? '0 : wc_q + 1'b1;
            act_q  <= eval ? '0 : act_sum;
            good_q <= good_nx;
            win_q  <= win_nx;
            if (state_q == S_LF_RST)
                rc_q <= rc_q + 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            relock_q <= 8'd0;
        else if (relock_inc && (relock_q != 8'hFF))
            relock_q <= relock_q + 8'd1;
    end

    assign bus.cp_en      = cp_en_q;
    assign bus.cp_gain_hi = gain_q;
    assign bus.lf_reset   = lf_q;
    assign bus.locked     = locked_q;
    assign bus.state      = state_q;
    assign bus.relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: a phase table, directed corner sequences and random PFD activity.
// Every cycle is compared against a rule-level model; a second small-parameter instance covers relock_cnt saturation.
module tb_pll_lock_seq;
    localparam int WIN_LEN      = 64;
    localparam int RST_CYC      = 16;
    localparam int LOCK_TOL     = 4;
    localparam int UNLOCK_TOL   = 16;
    localparam int ACQ_GOOD     = 2;
    localparam int LOCK_WINS    = 4;
    localparam int TIMEOUT_WINS = 32;

    localparam int M_IDLE = 0, M_LF_RST = 1, M_ACQ = 2, M_TRACK = 3, M_LOCKED = 4;

    logic refclk = 1'b0;
    logic rst_n  = 1'b1;
    always #5 refclk = ~refclk;

    pll_lock_seq_if bus();
    pll_lock_seq_if sbus();

    pll_lock_seq #(
        .WIN_LEN(WIN_LEN), .RST_CYC(RST_CYC), .LOCK_TOL(LOCK_TOL), .UNLOCK_TOL(UNLOCK_TOL),
        .ACQ_GOOD(ACQ_GOOD), .LOCK_WINS(LOCK_WINS), .TIMEOUT_WINS(TIMEOUT_WINS)
    ) u_dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pll_lock_seq #(
        .WIN_LEN(4), .RST_CYC(2), .LOCK_TOL(1), .UNLOCK_TOL(2),
        .ACQ_GOOD(2), .LOCK_WINS(2), .TIMEOUT_WINS(2)
    ) u_sat (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // Rule-level model: cycles of the current window, activity so far, window tallies.
    int m_st, m_wc, m_act, m_good, m_win, m_rc, m_relock;

    task automatic model_reset();
        m_st = M_IDLE; m_wc = 0; m_act = 0; m_good = 0; m_win = 0; m_rc = 0; m_relock = 0;
    endtask

    task automatic model_step(input bit en, input bit rs, input bit u, input bit d);
        int  nst, a;
        bit  ev, good, bad, enter;
        a = m_act + ((u || d) ? 1 : 0);
        if (a > WIN_LEN) a = WIN_LEN;
        ev   = (m_wc == WIN_LEN - 1);
        good = ev && (a <= LOCK_TOL);
        bad  = ev && (a > UNLOCK_TOL);
        nst  = m_st;
        if (!en) begin
            nst = M_IDLE; m_good = 0; m_win = 0;
        end else if (rs) begin
            nst = M_LF_RST;
        end else if (m_st == M_IDLE) begin
            nst = M_LF_RST;
        end else if (m_st == M_LF_RST) begin
            if (m_rc + 1 >= RST_CYC) nst = M_ACQ;
        end else if (ev && m_st == M_ACQ) begin
            m_win  = m_win + 1;
            m_good = good ? m_good + 1 : 0;
            if (m_good >= ACQ_GOOD) nst = M_TRACK;
            else if (m_win >= TIMEOUT_WINS) begin
                nst = M_LF_RST;
                if (m_relock < 255) m_relock++;
            end
        end else if (ev && m_st == M_TRACK) begin
            m_good = good ? m_good + 1 : 0;
            if (bad) nst = M_ACQ;
            else if (m_good >= LOCK_WINS) nst = M_LOCKED;
        end else if (ev && m_st == M_LOCKED && bad) begin
            nst = M_ACQ;
            if (m_relock < 255) m_relock++;
        end
        enter = (nst != m_st) || (en && rs);
        if (enter) begin
            m_wc = 0; m_act = 0; m_good = 0; m_win = 0; m_rc = 0;
        end else begin
            if (ev) begin m_wc = 0; m_act = 0; end
            else begin m_wc = m_wc + 1; m_act = a; end
            if (m_st == M_LF_RST) m_rc = m_rc + 1;
        end
        m_st = nst;
    endtask

    function automatic int model_vec();
        int cp, gn, lf, lk;
        cp = (m_st == M_ACQ || m_st == M_TRACK || m_st == M_LOCKED) ? 1 : 0;
        gn = (m_st == M_ACQ) ? 1 : 0;
        lf = (m_st == M_LF_RST) ? 1 : 0;
        lk = (m_st == M_LOCKED) ? 1 : 0;
        return (m_st << 12) | (cp << 11) | (gn << 10) | (lf << 9) | (lk << 8) | m_relock;
    endfunction

    function automatic int dut_vec();
        return int'({bus.state, bus.cp_en, bus.cp_gain_hi, bus.lf_reset, bus.locked, bus.relock_cnt});
    endfunction

    function automatic int dut_ctl();
        return int'({bus.cp_en, bus.cp_gain_hi, bus.lf_reset, bus.locked});
    endfunction

    task automatic cyc(input bit en, input bit rs, input bit u, input bit d);
        bus.enable = en; bus.restart = rs; bus.up = u; bus.down = d;
        @(posedge refclk);
        model_step(en, rs, u, d);
        #1;
        check("cycle_model", dut_vec(), model_vec());
    endtask

    // One aligned window with n_act active cycles at its end; the first has up and down together.
    task automatic window(input int n_act);
        for (int i = 0; i < WIN_LEN; i++)
            cyc(1'b1, 1'b0, i >= WIN_LEN - n_act, i == WIN_LEN - n_act);
    endtask

    task automatic do_reset();
        bus.enable = 1'b0; bus.restart = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
        sbus.enable = 1'b0; sbus.restart = 1'b0; sbus.up = 1'b0; sbus.down = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_outputs", dut_vec(), 0);
        check("reset_sat_outputs", int'({sbus.state, sbus.relock_cnt}), 0);
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         en;
        bit         rs;
        bit         up;
        bit         dn;
        int         ncyc;
        int         exp_st;
        logic [3:0] exp_ctl;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // {cp_en, cp_gain_hi, lf_reset, locked}
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 100, M_IDLE,   4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   M_LF_RST, 4'b0010};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 15,  M_LF_RST, 4'b0010};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   M_ACQ,    4'b1100};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 127, M_ACQ,    4'b1100};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   M_TRACK,  4'b1000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 255, M_TRACK,  4'b1000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   M_LOCKED, 4'b1001};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 40,  M_LOCKED, 4'b1001};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,   M_IDLE,   4'b0000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,   M_LF_RST, 4'b0010};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 144, M_TRACK,  4'b1000};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,   M_LF_RST, 4'b0010};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 15,  M_LF_RST, 4'b0010};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < tbl[i].ncyc; c++)
                cyc(tbl[i].en, tbl[i].rs, tbl[i].up, tbl[i].dn);
            check($sformatf("tbl%0d_state", i), int'(bus.state), tbl[i].exp_st);
            check($sformatf("tbl%0d_ctl", i), dut_ctl(), int'(tbl[i].exp_ctl));
            check($sformatf("tbl%0d_relock", i), int'(bus.relock_cnt), 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_lf_exit_state", int'(bus.state), M_ACQ);

        // Exactly LOCK_TOL activity per window still locks; then loss-of-lock thresholds.
        do_reset();
        repeat (145) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("tol4_enter_track", int'(bus.state), M_TRACK);
        repeat (4) window(4);
        check("tol4_locked_state", int'(bus.state), M_LOCKED);
        check("tol4_locked_out", int'(bus.locked), 1);
        window(16);
        check("unlock16_holds", int'(bus.state), M_LOCKED);
        check("unlock16_relock", int'(bus.relock_cnt), 0);
        window(17);
        check("unlock17_state", int'(bus.state), M_ACQ);
        check("unlock17_locked", int'(bus.locked), 0);
        check("unlock17_relock", int'(bus.relock_cnt), 1);

        // One window of 5 restarts the good-window count in TRACK.
        do_reset();
        repeat (145) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        window(4);
        window(5);
        repeat (3) window(4);
        check("tol5_delayed", int'(bus.state), M_TRACK);
        window(4);
        check("tol5_locked", int'(bus.state), M_LOCKED);

        // Continuous up: ACQUIRE times out after TIMEOUT_WINS windows.
        do_reset();
        repeat (2064) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("timeout_before_state", int'(bus.state), M_ACQ);
        check("timeout_before_relock", int'(bus.relock_cnt), 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("timeout_state", int'(bus.state), M_LF_RST);
        check("timeout_relock", int'(bus.relock_cnt), 1);
        repeat (15) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("timeout_lf_held", int'(bus.lf_reset), 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("timeout_reacquire", int'(bus.state), M_ACQ);

        // Asynchronous reset between clock edges, mid-ACQUIRE.
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", dut_vec(), 0);
        model_reset();
        @(negedge refclk);
        rst_n = 1'b1;

        // relock_cnt saturation on the small instance (10 cycles per timeout/retry).
        sbus.enable = 1'b1;
        sbus.up = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("sat_relock_%0d", k), int'(sbus.relock_cnt), (k < 255) ? k : 255);
            check($sformatf("sat_state_%0d", k), int'(sbus.state), M_LF_RST);
        end
        sbus.enable = 1'b0;
        sbus.up = 1'b0;

        // Random PFD activity with occasional restarts and enable drops.
        do_reset();
        begin
            int thr;
            bit en, rs, u, d;
            thr = 0;
            for (int i = 0; i < 20000; i++) begin
                if (i % 64 == 0) begin
                    case ($urandom_range(0, 4))
                        0: thr = 0;
                        1: thr = 5;
                        2: thr = 7;
                        3: thr = 20;
                        default: thr = 2;
                    endcase
                end
                en = ($urandom_range(0, 3999) != 0);
                rs = ($urandom_range(0, 2999) == 0);
                u  = ($urandom_range(0, 99) < thr);
                d  = ($urandom_range(0, 199) < thr);
                cyc(en, rs, u, d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_seq.md
Name: pll_lock_seq

Overview:
- Lock-acquisition sequencer for the PFD / charge-pump / loop-filter chain.
- Clocked by the reference clock. Watches the PFD up/down activity. Sequences three controls:
  - loop-filter reset (VRESET),
  - charge-pump enable,
  - charge-pump gain select.
- Declares lock after sustained quiet PFD windows; drops lock and re-acquires when activity returns.

Parameters:
- WIN_LEN, 64: cycles per observation window (>=4).
- RST_CYC, 16: cycles loop-filter reset is held in LF_RST.
- LOCK_TOL, 4: window activity <= this counts as a good window.
- UNLOCK_TOL, 16: window activity > this counts as a bad window (UNLOCK_TOL >= LOCK_TOL).
- ACQ_GOOD, 2: consecutive good windows in ACQUIRE before moving to TRACK.
- LOCK_WINS, 4: consecutive good windows in TRACK before LOCKED.
- TIMEOUT_WINS, 32: windows allowed in ACQUIRE before a filter reset and retry.

Ports:
- refclk, input, 1: clock; all state changes on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: level; 0 forces IDLE.
- restart, input, 1: one-cycle request to restart acquisition from LF_RST.
- up, input, 1: PFD up, already synchronous to refclk.
- down, input, 1: PFD down, already synchronous to refclk.
- cp_en, output, 1: charge-pump enable.
- cp_gain_hi, output, 1: 1 = high acquisition current; 0 = tracking current.
- lf_reset, output, 1: loop-filter reset (VRESET).
- locked, output, 1: lock indicator.
- state, output, 3: IDLE=0, LF_RST=1, ACQUIRE=2, TRACK=3, LOCKED=4.
- relock_cnt, output, 8: saturating count of lock losses and acquisition timeouts.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, all outputs 0, all internal counters 0.
- All outputs are registered, Moore-style decode of the state register; they change in the same cycle the state changes.
  - IDLE: all controls 0.
  - LF_RST: lf_reset=1.
  - ACQUIRE: cp_en=1, cp_gain_hi=1.
  - TRACK: cp_en=1.
  - LOCKED: cp_en=1, locked=1.
- Activity measurement:
  - Window counter wc runs 0..WIN_LEN-1 and clears on every state entry.
  - Activity counter act counts cycles where (up|down)=1. up&down together counts once. act saturates at WIN_LEN.
  - Evaluation happens on the cycle wc=WIN_LEN-1 and includes that cycle's activity. act then clears for the next window.
  - good = act <= LOCK_TOL; bad = act > UNLOCK_TOL; anything between is neutral.
- Transition priority: enable=0, then restart, then window evaluation, then LF_RST cycle count.
  - enable=0 from any state: IDLE next cycle; good/timeout counters clear.
  - restart=1 with enable=1 from any state, including IDLE and LF_RST: go to LF_RST and reload its cycle count.
  - IDLE to LF_RST: when enable=1.
  - LF_RST: held exactly RST_CYC cycles, then ACQUIRE.
- ACQUIRE:
  - A good window increments good_cnt; a neutral or bad window clears it.
  - good_cnt reaching ACQ_GOOD: go to TRACK.
  - Each window increments win_cnt. win_cnt reaching TIMEOUT_WINS with no exit: go to LF_RST and increment relock_cnt.
  - If both conditions hit on the same window, TRACK wins.
- TRACK:
  - A good window increments good_cnt; a neutral window clears it; a bad window sends the block to ACQUIRE (no relock_cnt increment).
  - good_cnt reaching LOCK_WINS: go to LOCKED.
- LOCKED:
  - A bad window sends the block to ACQUIRE; locked drops in that same cycle; relock_cnt increments.
  - Good and neutral windows hold lock.
- good_cnt and win_cnt clear on every state entry.
- relock_cnt holds at 255. It is cleared only by rst_n.
- rst_n asserted mid-operation: outputs go to 0 immediately, with no wait for a clock edge.

Test Plan:
- Reset/idle: rst_n low then high, enable=0 for 100 cycles -> state=0, all outputs 0.
- Clean acquisition (defaults): enable=1, up=down=0 throughout.
  - lf_reset=1 for exactly 16 cycles, starting the cycle after enable is sampled.
  - ACQUIRE with cp_gain_hi=1 for 128 cycles.
  - TRACK for 256 cycles.
  - locked=1 at cycle 1+16+128+256 after enable; relock_cnt=0.
- Tolerance boundary, in TRACK:
  - Exactly 4 active cycles per window (up and down overlapping in one cycle, counted once) -> LOCKED reached.
  - 5 active cycles in one window -> good_cnt clears and lock is delayed by the windows lost.
- Loss of lock: in LOCKED, inject 17 up-cycles in one window -> at that window's last cycle state=ACQUIRE, locked=0, relock_cnt=1. 16 up-cycles -> stays LOCKED.
- Timeout: enable=1 with up held 1 continuously -> after 32 windows in ACQUIRE, LF_RST for 16 cycles, relock_cnt increments. Repeat 300 times -> relock_cnt=255 and held.
- Priority/abort:
  - restart and enable=0 asserted together in LOCKED -> IDLE.
  - restart alone in TRACK -> LF_RST, lf_reset=1 for 16 cycles.
  - rst_n pulsed low mid-ACQUIRE between clock edges -> outputs 0 immediately.
